// File: rtl/id_pkg.sv
// id_pkg: shared opcode constants, FSM state encoding and decoded-entry layout for the ID stage.
package id_pkg;
    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 16;

    localparam logic [OP_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OPC_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OPC_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OPC_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OPC_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OPC_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
        logic             u;
        logic             is_imm;
        logic             illegal;
    } entry_t;
endpackage

// File: rtl/imm_ctrl_decode.sv
// imm_ctrl_decode: combinational instruction field split plus immediate-form and extension-mode decode.
module imm_ctrl_decode
    import id_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [OP_W-1:0]  opcode,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [IMM_W-1:0] immOut,
    output logic             U,
    output logic             isImm,
    output logic             illegal
);
    logic zext, sext;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign zext    = opcode inside {OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI};
    assign sext    = opcode inside {OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
                                    OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE};
    assign isImm   = zext | sext;
    assign U       = zext;
    assign illegal = !isImm && opcode != OPC_RTYPE;
    assign immOut  = isImm ? instr[IMM_W-1:0] : '0;
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: ID-stage register with 2-entry skid buffer feeding the immediate extension unit.
module imm_decode_stage
    import id_pkg::*;
#(
    parameter int M = 32,
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  opcode,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [N-1:0]     immOut,
    output logic             U,
    output logic             isImm,
    output logic             illegal
);
    state_e state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, dec;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    imm_ctrl_decode u_dec (
        .instr   (instr),
        .opcode  (dec.opcode),
        .rs      (dec.rs),
        .rt      (dec.rt),
        .immOut  (dec.imm),
        .U       (dec.u),
        .isImm   (dec.is_imm),
        .illegal (dec.illegal)
    );

    assign out_valid = state_q != ST_EMPTY;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) begin
                    main_d  = dec;
                    state_d = ST_ONE;
                end
                ST_ONE: if (accept && drain) begin
                    main_d  = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
                ST_FULL: if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // ready follows the state being entered so upstream sees it on the same edge
        in_ready_d = state_d != ST_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign opcode  = main_q.opcode;
    assign rs      = main_q.rs;
    assign rt      = main_q.rt;
    assign immOut  = main_q.imm;
    assign U       = main_q.u;
    assign isImm   = main_q.is_imm;
    assign illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: decode vector table plus handshake sequences (backpressure, throughput, flush, reset).
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [15:0] immOut;
    logic        U, isImm, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] recv[$];

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        u;
        logic        is_imm;
        logic        ill;
        logic [31:0] ext;
    } vec_t;
    vec_t vec[10];

    imm_decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .immOut    (immOut),
        .U         (U),
        .isImm     (isImm),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid && out_ready) recv.push_back(immOut);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ieu(input logic [15:0] imm, input logic u);
        return u ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, " data"}, {opcode, rs, rt, immOut}, 32'd0);
        chk({tag, " flags"}, {29'd0, U, isImm, illegal}, 32'd0);
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rt_i, input logic [15:0] imm);
        return {6'b001000, 5'd0, rt_i, imm};
    endfunction

    initial begin
        vec[0] = '{32'h2001FFF7, 6'b001000, 5'd0, 5'd1, 16'hFFF7, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF7};
        vec[1] = '{32'h3422000B, 6'b001101, 5'd1, 5'd2, 16'h000B, 1'b1, 1'b1, 1'b0, 32'h0000000B};
        vec[2] = '{32'h012A4020, 6'b000000, 5'd9, 5'd10, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h00000000};
        vec[3] = '{32'hFC000000, 6'b111111, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h00000000};
        vec[4] = '{32'h3C018000, 6'b001111, 5'd0, 5'd1, 16'h8000, 1'b1, 1'b1, 1'b0, 32'h00008000};
        vec[5] = '{32'h8C43FFFC, 6'b100011, 5'd2, 5'd3, 16'hFFFC, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC};
        vec[6] = '{32'h1085FFFE, 6'b000100, 5'd4, 5'd5, 16'hFFFE, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE};
        vec[7] = '{32'h30E47FFF, 6'b001100, 5'd7, 5'd4, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h00007FFF};
        vec[8] = '{32'h2CA68000, 6'b001011, 5'd5, 5'd6, 16'h8000, 1'b0, 1'b1, 1'b0, 32'hFFFF8000};
        vec[9] = '{32'h08001234, 6'b000010, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h00000000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;

        out_ready = 1'b1;
        foreach (vec[i]) begin
            in_valid = 1'b1;
            instr = vec[i].instr;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d fields", i), {opcode, rs, rt, immOut},
                {vec[i].op, vec[i].rs, vec[i].rt, vec[i].imm});
            chk($sformatf("v%0d flags", i), {29'd0, U, isImm, illegal},
                {29'd0, vec[i].u, vec[i].is_imm, vec[i].ill});
            chk($sformatf("v%0d ieu", i), ieu(immOut, U), vec[i].ext);
            step();
            chk($sformatf("v%0d drained", i), {31'd0, out_valid}, 32'd0);
        end

        // backpressure: A,B fill main+skid, C waits upstream
        recv.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = addi(5'd1, 16'h00A1);
        step();
        instr = addi(5'd2, 16'h00B2);
        step();
        chk("bp full in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp full head", {16'd0, immOut}, 32'h00A1);
        instr = addi(5'd3, 16'h00C3);
        step();
        step();
        chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp hold head", {16'd0, immOut}, 32'h00A1);
        chk("bp hold rt", {27'd0, rt}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp B head", {16'd0, immOut}, 32'h00B2);
        chk("bp B in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp C head", {16'd0, immOut}, 32'h00C3);
        step();
        chk("bp empty", {31'd0, out_valid}, 32'd0);
        chk("bp count", recv.size(), 32'd3);
        if (recv.size() == 3) begin
            chk("bp order0", {16'd0, recv[0]}, 32'h00A1);
            chk("bp order1", {16'd0, recv[1]}, 32'h00B2);
            chk("bp order2", {16'd0, recv[2]}, 32'h00C3);
        end

        // full throughput
        recv.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr = addi(5'(i), 16'h0100 + 16'(i));
            chk($sformatf("tp%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            step();
            chk($sformatf("tp%0d out", i), {15'd0, out_valid, immOut}, {15'd0, 1'b1, 16'h0100 + 16'(i)});
        end
        in_valid = 1'b0;
        step();
        chk("tp empty", {31'd0, out_valid}, 32'd0);
        chk("tp count", recv.size(), 32'd8);
        for (int i = 0; i < 8 && i < recv.size(); i++)
            chk($sformatf("tp order%0d", i), {16'd0, recv[i]}, 32'h0100 + i);

        // flush while FULL, with an upstream instruction pending
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = addi(5'd4, 16'h0D04);
        step();
        instr = addi(5'd5, 16'h0D05);
        step();
        chk("fl full in_ready", {31'd0, in_ready}, 32'd0);
        instr = addi(5'd6, 16'h0D06);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk_zero("flush full");
        // flush outranks a simultaneous accept and drain
        in_valid = 1'b1;
        instr = addi(5'd7, 16'h0D07);
        step();
        out_ready = 1'b1;
        instr = addi(5'd8, 16'h0D08);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk_zero("flush one");
        in_valid = 1'b1;
        instr = addi(5'd9, 16'h0D09);
        step();
        in_valid = 1'b0;
        chk("post flush", {15'd0, out_valid, immOut}, {15'd0, 1'b1, 16'h0D09});
        out_ready = 1'b1;
        step();
        chk("post flush drained", {31'd0, out_valid}, 32'd0);

        // illegal entry flows through, then reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1;
        instr = 32'hFC000000;
        step();
        instr = 32'h2001FFF7;
        step();
        in_valid = 1'b0;
        chk("ill full in_ready", {31'd0, in_ready}, 32'd0);
        chk("ill flags", {29'd0, U, isImm, illegal}, 32'd1);
        chk("ill data", {opcode, rs, rt, immOut}, {6'b111111, 26'd0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("reset full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
